mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single shared memory port used by instruction fetch (IF) and the memory stage (MEM). It accepts one request per requester, serialises them onto a request/acknowledge memory port with MEM priority, and holds the requester's stall output until its response is available. It sits between the IF/MEM pipeline stages and the unified memory model. It replaces direct dmem hookup in the MEM stage.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, number of BUSY cycles without PortAck before a forced completion; range 1..65535; used only with MEMARB_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- IFReq  in  1  fetch request; held until IFStall=0
- IFAddr  in  [0:31]  fetch address
- IFData  out  [0:31]  fetched word; valid while IFStall=0 after an IF service
- IFStall  out  1  IF must hold
- MEMReq  in  1  data access request; held until MEMStall=0
- MEMWE  in  1  1=write, 0=read
- MEMAddr  in  [0:31]  data address
- MEMWData  in  [0:31]  store data
- MEMSize  in  [0:1]  00 byte, 01 half, 10 word
- MEMExt  in  1  sign-extend loaded data
- MEMRData  out  [0:31]  load data
- MEMStall  out  1  MEM must hold
- PortReq  out  1  memory request, registered
- PortWE, PortAddr, PortWData, PortSize, PortExt  out  1/[0:31]/[0:31]/[0:1]/1  latched request fields
- PortRData  in  [0:31]  memory read data, sampled with PortAck
- PortAck  in  1  one-cycle completion pulse
- ErrTimeout  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, RESP_IF, RESP_MEM.
- IDLE: if MEMReq, latch MEM fields and go to BUSY_MEM. Else if IFReq, latch {WE=0, addr=IFAddr, size=10, ext=0, wdata=0} and go to BUSY_IF. Else stay.
- BUSY_x: PortReq=1. Port fields stay stable. On PortAck, capture PortRData into the x data register (writes leave MEMRData unchanged) and go to RESP_x.
- RESP_x: PortReq=0. Stall of requester x=0; go to IDLE next edge. No new request is issued in RESP.
- Stalls (combinational):
  - IFStall = IFReq & (state != RESP_IF).
  - MEMStall = MEMReq & (state != RESP_MEM).
- Simultaneous IFReq and MEMReq in IDLE: MEM is served first. IF is served starting from the IDLE that follows RESP_MEM.
- Requester drops Req mid-BUSY: the transaction still completes (it is not cancellable). The captured data is kept but no stall is involved.
- PortAck outside BUSY_x is ignored.
- Reset (asynchronous, reset=0):
  - State goes to IDLE.
  - PortReq, PortWE, PortAddr, PortWData, PortSize, PortExt, IFData, MEMRData, ErrTimeout, and the timeout counter all go to 0.
  - An in-flight access is abandoned.

## Timing
- Minimum service is 3 cycles: IDLE (request seen), BUSY (PortAck in the first BUSY cycle), RESP (stall=0, data valid).
- Each extra memory wait cycle adds 1 cycle.
- PortReq rises on the edge after the request is seen in IDLE. PortReq falls on the edge after PortAck.
- Back-to-back MEM then IF fetch, both with zero wait: IFStall=0 at cycle 6.
- IFData and MEMRData are registered and hold their value until the next capture for the same requester.

## Configuration
- MEMARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUSY and increments on each BUSY cycle without PortAck.
  - When the count reaches TIMEOUT_CYCLES, the arbiter goes to RESP_x with captured data 32'hDEADBEEF and sets ErrTimeout=1.
  - ErrTimeout stays 1 until reset.
  - A PortAck arriving in the same cycle as the timeout takes precedence: normal data is captured and there is no error.
- MEMARB_TIMEOUT_EN undefined:
  - No counter is built and ErrTimeout is tied to 0.
  - BUSY waits indefinitely for PortAck.

## Test plan
- Reset low mid-BUSY_MEM, PortAck pulse after release -> PortReq=0 immediately; state IDLE; all outputs 0; ack ignored.
- IFReq=1, IFAddr=32'h100, PortAck in first BUSY cycle with PortRData=32'h20010005 -> PortAddr=32'h100, PortSize=10, PortWE=0; IFStall=0 and IFData=32'h20010005 in cycle 3.
- IFReq and MEMReq (load, MEMAddr=32'h400, size 01, ext 1) together, 2 wait cycles each -> MEM port transaction first; MEMStall=0 at cycle 5; IF PortReq begins cycle 7.
- MEM store MEMWData=32'hCAFEF00D, MEMSize=00 -> PortWE=1 and fields stable throughout BUSY; MEMRData unchanged.
- MEMARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no PortAck -> RESP after 4 BUSY cycles; MEMRData=32'hDEADBEEF; ErrTimeout=1 and remains set across the next normal access.
- IFReq dropped during BUSY_IF, then PortAck -> RESP_IF, IFStall=0, IDLE next cycle; a pending MEMReq is served afterwards.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one request/acknowledge memory port between
// instruction fetch (IF) and the memory stage (MEM). MEM wins ties. The
// requester's stall drops for exactly one RESP cycle, when its data is valid.
// Optional feature: define MEMARB_TIMEOUT_EN to build the BUSY watchdog that
// forces completion with 32'hDEADBEEF and raises the sticky ErrTimeout flag.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch side
    input  logic        IFReq,
    input  logic [0:31] IFAddr,
    output logic [0:31] IFData,
    output logic        IFStall,
    // memory stage side
    input  logic        MEMReq,
    input  logic        MEMWE,
    input  logic [0:31] MEMAddr,
    input  logic [0:31] MEMWData,
    input  logic [0:1]  MEMSize,
    input  logic        MEMExt,
    output logic [0:31] MEMRData,
    output logic        MEMStall,
    // shared memory port
    output logic        PortReq,
    output logic        PortWE,
    output logic [0:31] PortAddr,
    output logic [0:31] PortWData,
    output logic [0:1]  PortSize,
    output logic        PortExt,
    input  logic [0:31] PortRData,
    input  logic        PortAck,
    // status
    output logic        ErrTimeout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BUSY_IF  = 3'd1,
        BUSY_MEM = 3'd2,
        RESP_IF  = 3'd3,
        RESP_MEM = 3'd4
    } state_t;

    localparam logic [0:31] TIMEOUT_DATA = 32'hDEADBEEF;
    localparam logic [0:1]  SIZE_WORD    = 2'b10;

    state_t      state_q, state_d;
    logic        port_req_q, port_req_d;
    logic        port_we_q, port_we_d;
    logic [0:31] port_addr_q, port_addr_d;
    logic [0:31] port_wdata_q, port_wdata_d;
    logic [0:1]  port_size_q, port_size_d;
    logic        port_ext_q, port_ext_d;
    logic [0:31] if_data_q, if_data_d;
    logic [0:31] mem_rdata_q, mem_rdata_d;
    logic [0:31] cap_data;
    logic        busy;
    logic        timeout_hit;

    assign busy = (state_q == BUSY_IF) || (state_q == BUSY_MEM);

`ifdef MEMARB_TIMEOUT_EN
    // The last BUSY cycle allowed before the forced completion.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;

    // Watchdog count: zeroed while idle so every BUSY entry starts at 0,
    // bumped on each BUSY cycle that passes without PortAck; error is sticky.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if (busy && !PortAck) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
        if (busy && timeout_hit && !PortAck) begin
            err_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign timeout_hit = (tmo_cnt_q == TMO_LAST);
    assign ErrTimeout  = err_q;
`else
    assign timeout_hit = 1'b0;
    assign ErrTimeout  = 1'b0;
`endif

    // Next-state and port-field logic: pick a requester in IDLE, wait for the
    // acknowledge (or watchdog) in BUSY, then spend one cycle in RESP.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        port_req_d   = port_req_q;
        port_we_d    = port_we_q;
        port_addr_d  = port_addr_q;
        port_wdata_d = port_wdata_q;
        port_size_d  = port_size_q;
        port_ext_d   = port_ext_q;
        if_data_d    = if_data_q;
        mem_rdata_d  = mem_rdata_q;
        cap_data     = PortAck ? PortRData : TIMEOUT_DATA;

        case (state_q)
            IDLE: begin
                if (MEMReq) begin
                    state_d      = BUSY_MEM;
                    port_req_d   = 1'b1;
                    port_we_d    = MEMWE;
                    port_addr_d  = MEMAddr;
                    port_wdata_d = MEMWData;
                    port_size_d  = MEMSize;
                    port_ext_d   = MEMExt;
                end else if (IFReq) begin
                    state_d      = BUSY_IF;
                    port_req_d   = 1'b1;
                    port_we_d    = 1'b0;
                    port_addr_d  = IFAddr;
                    port_wdata_d = '0;
                    port_size_d  = SIZE_WORD;
                    port_ext_d   = 1'b0;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                // An acknowledge in the watchdog's final cycle wins: real data, no error.
                if (PortAck || timeout_hit) begin
                    port_req_d = 1'b0;
                    if (state_q == BUSY_IF) begin
                        state_d   = RESP_IF;
                        if_data_d = cap_data;
                    end else begin
                        state_d = RESP_MEM;
                        // Stores complete without disturbing the last load result.
                        if (!port_we_q) begin
                            mem_rdata_d = cap_data;
                        end
                    end
                end
            end
            RESP_IF, RESP_MEM: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                port_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            port_req_q   <= 1'b0;
            port_we_q    <= 1'b0;
            port_addr_q  <= '0;
            port_wdata_q <= '0;
            port_size_q  <= '0;
            port_ext_q   <= 1'b0;
            if_data_q    <= '0;
            mem_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together from pre-edge values.
            state_q      <= state_d;
            port_req_q   <= port_req_d;
            port_we_q    <= port_we_d;
            port_addr_q  <= port_addr_d;
            port_wdata_q <= port_wdata_d;
            port_size_q  <= port_size_d;
            port_ext_q   <= port_ext_d;
            if_data_q    <= if_data_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    // A requester stalls whenever it asks and is not in its own RESP cycle.
    assign IFStall   = IFReq  && (state_q != RESP_IF);
    assign MEMStall  = MEMReq && (state_q != RESP_MEM);

    assign PortReq   = port_req_q;
    assign PortWE    = port_we_q;
    assign PortAddr  = port_addr_q;
    assign PortWData = port_wdata_q;
    assign PortSize  = port_size_q;
    assign PortExt   = port_ext_q;
    assign IFData    = if_data_q;
    assign MEMRData  = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Table-driven single transactions
// with a scoreboard queue, plus hand-written multi-cycle sequences. Build with
// MEMARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT_CYCLES=4).
module tb_mem_port_arbiter;

`ifdef MEMARB_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        IFReq, MEMReq, MEMWE, MEMExt, PortAck;
    logic [0:31] IFAddr, MEMAddr, MEMWData, PortRData;
    logic [0:1]  MEMSize;
    logic [0:31] IFData, MEMRData, PortAddr, PortWData;
    logic        IFStall, MEMStall, PortReq, PortWE, PortExt, ErrTimeout;
    logic [0:1]  PortSize;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .IFReq(IFReq), .IFAddr(IFAddr), .IFData(IFData), .IFStall(IFStall),
        .MEMReq(MEMReq), .MEMWE(MEMWE), .MEMAddr(MEMAddr), .MEMWData(MEMWData),
        .MEMSize(MEMSize), .MEMExt(MEMExt), .MEMRData(MEMRData), .MEMStall(MEMStall),
        .PortReq(PortReq), .PortWE(PortWE), .PortAddr(PortAddr), .PortWData(PortWData),
        .PortSize(PortSize), .PortExt(PortExt), .PortRData(PortRData), .PortAck(PortAck),
        .ErrTimeout(ErrTimeout)
    );

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [0:31] addr;
        logic [0:31] wdata;
        logic [0:1]  size;
        bit          ext;
        int          waits;
        logic [0:31] rdata;
        logic [0:31] exp_data;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [0:31] exp_q[$];
    vec_t        vecs[6];
    vec_t        post_rst;
    vec_t        after_tmo;

    task automatic check(input string name, input logic [0:31] act, input logic [0:31] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, " PortReq"}, PortReq, 1'b0);
        check_bit({tag, " PortWE"}, PortWE, 1'b0);
        check({tag, " PortAddr"}, PortAddr, 32'h0);
        check({tag, " PortWData"}, PortWData, 32'h0);
        check({tag, " PortSize"}, 32'(PortSize), 32'h0);
        check_bit({tag, " PortExt"}, PortExt, 1'b0);
        check({tag, " IFData"}, IFData, 32'h0);
        check({tag, " MEMRData"}, MEMRData, 32'h0);
        check_bit({tag, " ErrTimeout"}, ErrTimeout, 1'b0);
    endtask

    // One complete transaction: drive the request, play the memory with
    // v.waits extra wait cycles, compare the data popped from the scoreboard.
    task automatic serve(input vec_t v, input string tag);
        int          busy = 0;
        bit          done = 0;
        logic [0:31] exp_d;
        if (v.is_mem) begin
            MEMReq = 1'b1; MEMWE = v.we; MEMAddr = v.addr;
            MEMWData = v.wdata; MEMSize = v.size; MEMExt = v.ext;
        end else begin
            IFReq = 1'b1; IFAddr = v.addr;
        end
        exp_q.push_back(v.exp_data);
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            if (!(v.is_mem ? MEMStall : IFStall)) begin
                check({tag, " latency"}, 32'(cyc), 32'(3 + v.waits));
                check_bit({tag, " PortReq in RESP"}, PortReq, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s: scoreboard empty at response", tag);
                end else begin
                    exp_d = exp_q.pop_front();
                    check({tag, " data"}, v.is_mem ? MEMRData : IFData, exp_d);
                end
                done = 1;
            end else if (PortReq) begin
                busy++;
                check_bit({tag, " PortWE"}, PortWE, v.is_mem ? v.we : 1'b0);
                check({tag, " PortAddr"}, PortAddr, v.addr);
                check({tag, " PortWData"}, PortWData, v.is_mem ? v.wdata : 32'h0);
                check({tag, " PortSize"}, 32'(PortSize), 32'(v.is_mem ? v.size : 2'b10));
                check_bit({tag, " PortExt"}, PortExt, v.is_mem ? v.ext : 1'b0);
                if (busy == v.waits + 1) begin
                    PortAck = 1'b1;
                    PortRData = v.rdata;
                end
            end
            align();
            PortAck = 1'b0;
            PortRData = $urandom;
        end
        if (v.is_mem) MEMReq = 1'b0;
        else IFReq = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s: no response within 40 cycles", tag);
        end
    endtask

    initial begin
        // is_mem we addr wdata size ext waits rdata exp_data
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 2'b10, 1'b0, 0, 32'h2001_0005, 32'h2001_0005};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h5555_0000, 2'b10, 1'b0, 1, 32'h1122_3344, 32'h1122_3344};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0203, 32'hCAFE_F00D, 2'b00, 1'b0, 2, 32'h9999_9999, 32'h1122_3344};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 2'b10, 1'b0, 3, 32'hA5A5_0001, 32'hA5A5_0001};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0007, 32'h0, 2'b00, 1'b1, 0, 32'hFFFF_FF80, 32'hFFFF_FF80};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_BEEF, 2'b01, 1'b0, 0, 32'h0, 32'hFFFF_FF80};
        post_rst  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0, 2'b10, 1'b0, 0, 32'h1357_2468, 32'h1357_2468};
        after_tmo = '{1'b1, 1'b0, 32'h0000_0304, 32'h0, 2'b10, 1'b0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D};

        reset = 1'b0; IFReq = 1'b0; MEMReq = 1'b0; MEMWE = 1'b0; MEMExt = 1'b0;
        IFAddr = '0; MEMAddr = '0; MEMWData = '0; MEMSize = '0;
        PortAck = 1'b0; PortRData = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check_bit("reset IFStall", IFStall, 1'b0);
        check_bit("reset MEMStall", MEMStall, 1'b0);
        reset = 1'b1;
        align();

        // Table-driven single transactions.
        for (int i = 0; i < 6; i++) begin
            serve(vecs[i], $sformatf("vec%0d", i));
        end
        @(negedge clk);
        check("IFData held across MEM accesses", IFData, 32'hA5A5_0001);
        align();

        // Simultaneous IF and MEM, two wait cycles each: MEM first.
        IFReq = 1'b1; IFAddr = 32'h0000_0800;
        MEMReq = 1'b1; MEMWE = 1'b0; MEMAddr = 32'h0000_0400;
        MEMWData = 32'h0; MEMSize = 2'b01; MEMExt = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            case (cyc)
                1: begin
                    check_bit("both c1 PortReq", PortReq, 1'b0);
                    check_bit("both c1 MEMStall", MEMStall, 1'b1);
                    check_bit("both c1 IFStall", IFStall, 1'b1);
                end
                2, 3, 4: begin
                    check_bit("both MEM PortReq", PortReq, 1'b1);
                    check("both MEM PortAddr", PortAddr, 32'h0000_0400);
                    check("both MEM PortSize", 32'(PortSize), 32'(2'b01));
                    check_bit("both MEM PortExt", PortExt, 1'b1);
                    check_bit("both MEM MEMStall", MEMStall, 1'b1);
                    if (cyc == 4) begin
                        PortAck = 1'b1; PortRData = 32'hFFFF_8001;
                    end
                end
                5: begin
                    check_bit("both c5 MEMStall", MEMStall, 1'b0);
                    check("both c5 MEMRData", MEMRData, 32'hFFFF_8001);
                    check_bit("both c5 PortReq", PortReq, 1'b0);
                    check_bit("both c5 IFStall", IFStall, 1'b1);
                end
                6: begin
                    check_bit("both c6 PortReq", PortReq, 1'b0);
                    check_bit("both c6 IFStall", IFStall, 1'b1);
                end
                7, 8, 9: begin
                    check_bit("both IF PortReq", PortReq, 1'b1);
                    check("both IF PortAddr", PortAddr, 32'h0000_0800);
                    check("both IF PortSize", 32'(PortSize), 32'(2'b10));
                    check_bit("both IF IFStall", IFStall, 1'b1);
                    if (cyc == 9) begin
                        PortAck = 1'b1; PortRData = 32'h0BAD_C0DE;
                    end
                end
                default: begin
                    check_bit("both c10 IFStall", IFStall, 1'b0);
                    check("both c10 IFData", IFData, 32'h0BAD_C0DE);
                end
            endcase
            align();
            PortAck = 1'b0;
            if (cyc == 5) MEMReq = 1'b0;
        end
        IFReq = 1'b0;

        // IF drops its request mid-BUSY while MEM becomes pending.
        IFReq = 1'b1; IFAddr = 32'h0000_0C00;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            case (cyc)
                1: begin
                    check_bit("drop c1 IFStall", IFStall, 1'b1);
                    check_bit("drop c1 PortReq", PortReq, 1'b0);
                end
                2, 3: begin
                    check_bit("drop BUSY PortReq", PortReq, 1'b1);
                    check("drop BUSY PortAddr", PortAddr, 32'h0000_0C00);
                    check_bit("drop BUSY MEMStall", MEMStall, 1'b1);
                    if (cyc == 3) begin
                        PortAck = 1'b1; PortRData = 32'h600D_F00D;
                    end
                end
                4: begin
                    check_bit("drop c4 IFStall", IFStall, 1'b0);
                    check("drop c4 IFData", IFData, 32'h600D_F00D);
                    check_bit("drop c4 PortReq", PortReq, 1'b0);
                    check_bit("drop c4 MEMStall", MEMStall, 1'b1);
                end
                5: begin
                    check_bit("drop c5 PortReq", PortReq, 1'b0);
                    check_bit("drop c5 MEMStall", MEMStall, 1'b1);
                end
                6: begin
                    check_bit("drop c6 PortReq", PortReq, 1'b1);
                    check("drop c6 PortAddr", PortAddr, 32'h0000_0500);
                    PortAck = 1'b1; PortRData = 32'h1212_1212;
                end
                default: begin
                    check_bit("drop c7 MEMStall", MEMStall, 1'b0);
                    check("drop c7 MEMRData", MEMRData, 32'h1212_1212);
                end
            endcase
            align();
            PortAck = 1'b0;
            if (cyc == 1) begin
                IFReq = 1'b0;
                MEMReq = 1'b1; MEMWE = 1'b0; MEMAddr = 32'h0000_0500;
                MEMSize = 2'b10; MEMExt = 1'b0;
            end
            if (cyc == 7) MEMReq = 1'b0;
        end

        // Reset asserted mid-BUSY_MEM, then a stray acknowledge.
        MEMReq = 1'b1; MEMWE = 1'b0; MEMAddr = 32'h0000_0900; MEMSize = 2'b10;
        align();
        @(negedge clk);
        check_bit("rst busy PortReq before", PortReq, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst async");
        MEMReq = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        align();
        PortAck = 1'b1; PortRData = 32'h1234_5678;
        align();
        PortAck = 1'b0;
        @(negedge clk);
        check_bit("rst stray ack PortReq", PortReq, 1'b0);
        check("rst stray ack MEMRData", MEMRData, 32'h0);
        check("rst stray ack IFData", IFData, 32'h0);
        align();
        serve(post_rst, "post_reset");

`ifdef MEMARB_TIMEOUT_EN
        // Watchdog: no acknowledge for TIMEOUT_CYCLES BUSY cycles.
        MEMReq = 1'b1; MEMWE = 1'b0; MEMAddr = 32'h0000_0300; MEMSize = 2'b10; MEMExt = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check_bit("tmo c1 PortReq", PortReq, 1'b0);
            end else if (cyc <= 5) begin
                check_bit("tmo BUSY PortReq", PortReq, 1'b1);
                check_bit("tmo BUSY MEMStall", MEMStall, 1'b1);
                check_bit("tmo BUSY ErrTimeout", ErrTimeout, 1'b0);
            end else begin
                check_bit("tmo c6 MEMStall", MEMStall, 1'b0);
                check("tmo c6 MEMRData", MEMRData, 32'hDEAD_BEEF);
                check_bit("tmo c6 ErrTimeout", ErrTimeout, 1'b1);
                check_bit("tmo c6 PortReq", PortReq, 1'b0);
            end
            align();
        end
        MEMReq = 1'b0;
        serve(after_tmo, "after_timeout");
        @(negedge clk);
        check_bit("ErrTimeout sticky", ErrTimeout, 1'b1);
`else
        serve(after_tmo, "no_timeout_build");
        @(negedge clk);
        check_bit("ErrTimeout tied low", ErrTimeout, 1'b0);
`endif

        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
